// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with registered read data, occupancy
// count, full/empty/almost flags, and overflow/underflow indications.
// Optional feature: define FIFO_STICKY_ERR_EN to make over_flow/under_flow
// latch until reset; otherwise they are one-cycle registered pulses.
module sync_fifo_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int AF_LVL = 28,
  parameter int AE_LVL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrt_sig,
  input  logic              rd_sig,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full_sig,
  output logic              empty_sig,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              over_flow,
  output logic              under_flow,
  output logic [ADDR_W:0]   count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LVL);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LVL);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W:0]   count_next;
  logic              wr_acc;
  logic              rd_acc;
  logic              wr_rej;
  logic              rd_rej;
  logic              of_next;
  logic              uf_next;

  // Accept/reject decisions and next occupancy; a read frees a slot so a
  // write is still accepted when full if a read happens on the same edge.
  always_comb begin
    rd_acc     = rd_sig & ~empty_sig;
    wr_acc     = wrt_sig & (~full_sig | rd_acc);
    wr_rej     = wrt_sig & ~wr_acc;
    rd_rej     = rd_sig & ~rd_acc;
    count_next = count;
    if (wr_acc && !rd_acc) begin
      count_next = count + ONE_C;
    end else if (rd_acc && !wr_acc) begin
      count_next = count - ONE_C;
    end else begin
      count_next = count;
    end
`ifdef FIFO_STICKY_ERR_EN
    of_next = over_flow | wr_rej;
    uf_next = under_flow | rd_rej;
`else
    of_next = wr_rej;
    uf_next = rd_rej;
`endif
  end

  // Storage array: no reset so it maps onto RAM; written only on accepted writes.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr[ADDR_W-1:0]] <= din;
    end
  end

  // Read data register: loads on an accepted read, otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= {DATA_W{1'b0}};
    end else if (rd_acc) begin
      dout <= mem[rd_ptr[ADDR_W-1:0]];
    end else begin
      dout <= dout;
    end
  end

  // Pointers, occupancy, status flags and error indications.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= {(ADDR_W+1){1'b0}};
      rd_ptr       <= {(ADDR_W+1){1'b0}};
      count        <= {(ADDR_W+1){1'b0}};
      full_sig     <= 1'b0;
      empty_sig    <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      over_flow    <= 1'b0;
      under_flow   <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ONE_C;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + ONE_C;
      end
      count        <= count_next;
      full_sig     <= (count_next == DEPTH_C);
      empty_sig    <= (count_next == {(ADDR_W+1){1'b0}});
      almost_full  <= (count_next >= AF_C);
      almost_empty <= (count_next <= AE_C);
      over_flow    <= of_next;
      under_flow   <= uf_next;
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param (default parameters).
// Honors FIFO_STICKY_ERR_EN for the expected overflow/underflow behaviour.
module tb_sync_fifo_param;

  logic       clk;
  logic       rst;
  logic       wrt_sig;
  logic       rd_sig;
  logic [7:0] din;
  logic [7:0] dout;
  logic       full_sig;
  logic       empty_sig;
  logic       almost_full;
  logic       almost_empty;
  logic       over_flow;
  logic       under_flow;
  logic [5:0] count;

  int tests_run;
  int tests_failed;

`ifdef FIFO_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  sync_fifo_param dut (
    .clk(clk), .rst(rst), .wrt_sig(wrt_sig), .rd_sig(rd_sig), .din(din),
    .dout(dout), .full_sig(full_sig), .empty_sig(empty_sig),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .over_flow(over_flow), .under_flow(under_flow), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {full, almost_full, empty, almost_empty} for an occupancy.
  function automatic logic [3:0] exp_flags(input int c);
    exp_flags = {c == 32, c >= 28, c == 0, c <= 4};
  endfunction

  // Drive one clock of stimulus, then settle 1 time unit past the edge.
  task automatic cycle(input logic w, input logic r, input logic [7:0] d);
    wrt_sig = w;
    rd_sig  = r;
    din     = d;
    @(posedge clk);
    #1;
    wrt_sig = 1'b0;
    rd_sig  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wrt_sig = 1'b0;
    rd_sig = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (count !== 6'd0) begin
      tests_failed++; $display("FAIL reset_count got %0d want 0", count);
    end
    tests_run++;
    if ({full_sig, almost_full, empty_sig, almost_empty} !== 4'b0011) begin
      tests_failed++;
      $display("FAIL reset_flags got %b want 0011", {full_sig, almost_full, empty_sig, almost_empty});
    end
    tests_run++;
    if ({over_flow, under_flow} !== 2'b00 || dout !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_err_dout got of=%b uf=%b dout=%h want 0 0 00", over_flow, under_flow, dout);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    cycle(1'b1 ^ 1'b1, 1'b1, 8'h00);
    tests_run++;
    if (under_flow !== 1'b1 || dout !== 8'h00 || count !== 6'd0) begin
      tests_failed++;
      $display("FAIL underflow got uf=%b dout=%h cnt=%0d want 1 00 0", under_flow, dout, count);
    end
    cycle(1'b0, 1'b0, 8'h00);
    tests_run++;
    if (under_flow !== STICKY) begin
      tests_failed++; $display("FAIL underflow_after got %b want %b", under_flow, STICKY);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      cycle(1'b1, 1'b0, 8'(i));
      tests_run++;
      if (count !== 6'(i + 1)) begin
        tests_failed++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i + 1);
      end
      tests_run++;
      if ({full_sig, almost_full, empty_sig, almost_empty} !== exp_flags(i + 1)) begin
        tests_failed++;
        $display("FAIL fill_flags[%0d] got %b want %b", i,
                 {full_sig, almost_full, empty_sig, almost_empty}, exp_flags(i + 1));
      end
    end
  endtask

  task automatic test_overflow_drain();
    cycle(1'b1, 1'b0, 8'hAA);
    tests_run++;
    if (over_flow !== 1'b1 || count !== 6'd32 || full_sig !== 1'b1) begin
      tests_failed++;
      $display("FAIL overflow got of=%b cnt=%0d full=%b want 1 32 1", over_flow, count, full_sig);
    end
    cycle(1'b0, 1'b0, 8'h00);
    tests_run++;
    if (over_flow !== STICKY) begin
      tests_failed++; $display("FAIL overflow_after got %b want %b", over_flow, STICKY);
    end
    for (int i = 0; i < 32; i++) begin
      cycle(1'b0, 1'b1, 8'h00);
      tests_run++;
      if (dout !== 8'(i) || count !== 6'(31 - i)) begin
        tests_failed++;
        $display("FAIL drain[%0d] got dout=%h cnt=%0d want %h %0d", i, dout, count, 8'(i), 31 - i);
      end
    end
    tests_run++;
    if (empty_sig !== 1'b1 || almost_empty !== 1'b1) begin
      tests_failed++; $display("FAIL drain_empty got e=%b ae=%b want 1 1", empty_sig, almost_empty);
    end
  endtask

  task automatic test_full_simul();
    do_reset();
    for (int i = 0; i < 32; i++) cycle(1'b1, 1'b0, 8'(i));
    cycle(1'b1, 1'b1, 8'h55);
    tests_run++;
    if (dout !== 8'h00 || count !== 6'd32 || over_flow !== 1'b0 || full_sig !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_simul got dout=%h cnt=%0d of=%b full=%b want 00 32 0 1",
               dout, count, over_flow, full_sig);
    end
    for (int i = 1; i < 33; i++) begin
      logic [7:0] want;
      want = (i == 32) ? 8'h55 : 8'(i);
      cycle(1'b0, 1'b1, 8'h00);
      tests_run++;
      if (dout !== want) begin
        tests_failed++; $display("FAIL full_simul_drain[%0d] got %h want %h", i, dout, want);
      end
    end
  endtask

  task automatic test_empty_simul();
    do_reset();
    cycle(1'b1, 1'b1, 8'h77);
    tests_run++;
    if (count !== 6'd1 || under_flow !== 1'b1 || dout !== 8'h00) begin
      tests_failed++;
      $display("FAIL empty_simul got cnt=%0d uf=%b dout=%h want 1 1 00", count, under_flow, dout);
    end
    cycle(1'b0, 1'b1, 8'h00);
    tests_run++;
    if (dout !== 8'h77 || count !== 6'd0) begin
      tests_failed++; $display("FAIL empty_simul_read got dout=%h cnt=%0d want 77 0", dout, count);
    end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] exp_dout;
    logic       exp_of;
    logic       exp_uf;
    logic       w;
    logic       r;
    logic       wa;
    logic       ra;
    logic [7:0] d;
    int         cnt;
    do_reset();
    cnt = 0; exp_dout = 8'h00; exp_of = 1'b0; exp_uf = 1'b0;
    for (int i = 0; i < 100; i++) begin
      w = (i < 60) ? 1'b1 : ((i % 4) == 0);
      r = (i < 60) ? ((i % 3) == 0) : 1'b1;
      d = 8'($urandom_range(0, 255));
      ra = r && (cnt > 0);
      wa = w && ((cnt < 32) || ra);
      if (ra) exp_dout = q.pop_front();
      if (wa) q.push_back(d);
      cnt = cnt + (wa ? 1 : 0) - (ra ? 1 : 0);
      exp_of = (STICKY ? exp_of : 1'b0) | (w && !wa);
      exp_uf = (STICKY ? exp_uf : 1'b0) | (r && !ra);
      cycle(w, r, d);
      tests_run++;
      if (dout !== exp_dout || count !== 6'(cnt) ||
          {full_sig, almost_full, empty_sig, almost_empty} !== exp_flags(cnt) ||
          {over_flow, under_flow} !== {exp_of, exp_uf}) begin
        tests_failed++;
        $display("FAIL random[%0d] got dout=%h cnt=%0d fl=%b err=%b want %h %0d %b %b", i,
                 dout, count, {full_sig, almost_full, empty_sig, almost_empty},
                 {over_flow, under_flow}, exp_dout, cnt, exp_flags(cnt), {exp_of, exp_uf});
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 8'(i + 8'h40));
    cycle(1'b0, 1'b1, 8'h00);
    tests_run++;
    if (count !== 6'd9 || dout !== 8'h40) begin
      tests_failed++; $display("FAIL pre_async got cnt=%0d dout=%h want 9 40", count, dout);
    end
    cycle(1'b1, 1'b0, 8'h49);
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (count !== 6'd0 || dout !== 8'h00 ||
        {full_sig, almost_full, empty_sig, almost_empty, over_flow, under_flow} !== 6'b001100) begin
      tests_failed++;
      $display("FAIL async_reset got cnt=%0d dout=%h flags=%b want 0 00 001100", count, dout,
               {full_sig, almost_full, empty_sig, almost_empty, over_flow, under_flow});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(1'b0, 1'b1, 8'h00);
    tests_run++;
    if (under_flow !== 1'b1 || count !== 6'd0 || dout !== 8'h00) begin
      tests_failed++;
      $display("FAIL post_async_read got uf=%b cnt=%0d dout=%h want 1 0 00", under_flow, count, dout);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1;
    wrt_sig = 1'b0;
    rd_sig = 1'b0;
    din = 8'h00;
    test_reset();
    test_underflow();
    test_fill();
    test_overflow_drain();
    test_full_simul();
    test_empty_simul();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 SHALL be clocked by a single clock, clk; reset is asynchronous and active-high, named rst.
REQ-002 Parameter DATA_W, default 8, SHALL set the data word width in bits.
REQ-003 Parameter ADDR_W, default 5, SHALL set the address width; depth = 2^ADDR_W (32 words).
REQ-004 Parameter AF_LVL, default 28, SHALL set the almost-full threshold in words.
REQ-005 Parameter AE_LVL, default 4, SHALL set the almost-empty threshold in words.
REQ-006 Ports SHALL be as follows:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous active-high reset.
- wrt_sig, input, 1: write request.
- rd_sig, input, 1: read request.
- din, input, DATA_W: write data.
- dout, output, DATA_W: registered read data.
- full_sig, output, 1: count == depth.
- empty_sig, output, 1: count == 0.
- almost_full, output, 1: count >= AF_LVL.
- almost_empty, output, 1: count <= AE_LVL.
- over_flow, output, 1: write rejected.
- under_flow, output, 1: read rejected.
- count, output, ADDR_W+1: current occupancy, 0..depth.

Function
REQ-007 A write SHALL be accepted on a clk edge when wrt_sig=1 and (full_sig=0 or a read is accepted on the same edge); din is stored at the write pointer.
REQ-008 A read SHALL be accepted on a clk edge when rd_sig=1 and empty_sig=0; dout SHALL take the word at the read pointer on that same edge (1-cycle latency from rd_sig sampled).
REQ-009 dout SHALL hold its last value whenever no read is accepted.
REQ-010 Write and read pointers SHALL be ADDR_W+1 bits; the low ADDR_W bits address memory, and the pointers wrap from depth-1 to 0 without gaps.
REQ-011 count SHALL be +1 on a write-only edge, -1 on a read-only edge, and unchanged on simultaneous accepted read+write or neither.
REQ-012 full_sig, empty_sig, almost_full, and almost_empty SHALL be registered and consistent with count in the same cycle.
REQ-013 When full, simultaneous wrt_sig+rd_sig SHALL accept both operations, leaving count = depth and over_flow unasserted.
REQ-014 When empty, simultaneous wrt_sig+rd_sig SHALL accept the write only (no bypass), reject the read, assert under_flow, and hold dout.
REQ-015 A write rejected because the FIFO is full SHALL leave memory and pointers unchanged and assert over_flow.
REQ-016 A read rejected because the FIFO is empty SHALL leave pointers unchanged and assert under_flow.
REQ-017 Storage SHALL be inferred RAM of depth x DATA_W, written only on accepted writes.

Reset
REQ-018 Asserting rst SHALL immediately, without waiting for clk, clear the pointers and count to 0 and set empty_sig=1, almost_empty=1, full_sig=0, almost_full=0, over_flow=0, under_flow=0, dout=0.
REQ-019 Memory contents SHALL NOT be reset; reset mid-operation discards all stored words.
REQ-020 The first accepted operation SHALL occur on the first clk edge after rst deasserts.

Configuration
REQ-021 With macro FIFO_STICKY_ERR_EN defined, over_flow and under_flow SHALL latch at 1 once set and clear only on rst.
REQ-022 Without FIFO_STICKY_ERR_EN, over_flow and under_flow SHALL be single-cycle pulses, registered, high for exactly the cycle after each rejected request.

Verification
REQ-023 Apply reset, then write 32 words 0x00..0x1F -> full_sig=1 and count=32 after the 32nd edge; almost_full rises after the 28th write.
REQ-024 Write a 33rd word 0xAA while full -> over_flow=1 (pulse, or sticky with FIFO_STICKY_ERR_EN) and memory unchanged; a subsequent drain reads 0x00..0x1F in order with no 0xAA.
REQ-025 Read while empty after reset -> under_flow=1, dout stays 0x00, count stays 0.
REQ-026 Fill to 32, then assert wrt_sig+rd_sig with din=0x55 for 1 cycle -> dout=0x00, count=32, no over_flow; 0x55 later emerges as the 32nd read.
REQ-027 Run 100 random write/read cycles across pointer wrap -> dout order matches a scoreboard; count and flags match the model on every cycle.
REQ-028 Assert rst mid-stream with count=10 -> outputs take reset values immediately, before the next clk edge; the next read after reset reports under_flow.
